// File: rtl/maj_vote_pkg.sv
// Shared definitions for the majority-vote filter: FSM state encoding,
// popcount width helper and parameter legality check.
package maj_vote_pkg;

  typedef logic state_t;

  localparam state_t STABLE = 1'b0;
  localparam state_t PEND   = 1'b1;

  function automatic int pop_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Odd channel count keeps a strict majority well defined.
  function automatic bit params_legal(input int n_in, input int thresh, input int hold);
    return (n_in % 2 == 1) && (n_in >= 3) && (n_in <= 31) &&
           (thresh >= 1) && (thresh <= n_in) && (hold >= 1);
  endfunction

endpackage

// File: rtl/maj_vote_popcount.sv
// Combinational population count of an N_IN-bit vector.
module maj_vote_popcount #(
  parameter int N_IN  = 3,
  parameter int POP_W = 2
) (
  input  logic [N_IN-1:0]  vec,
  output logic [POP_W-1:0] pop
);

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_IN; i++) begin
      pop = pop + POP_W'(vec[i]);
    end
  end

endmodule

// File: rtl/maj_vote_filter.sv
// Two-stage threshold voter with a persistence filter on the vote.
// Optional dissent counter enabled by defining MAJ_VOTE_DISSENT_EN.
module maj_vote_filter
  import maj_vote_pkg::*;
#(
  parameter int   N_IN     = 3,
  parameter int   THRESH   = N_IN / 2 + 1,
  parameter int   HOLD     = 4,
  parameter logic INIT_VAL = 1'b0,
  parameter int   CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [N_IN-1:0]            in_bits,
  output logic                       out_valid,
  output logic                       out_vote,
  output logic                       out_raw,
  output logic [$clog2(N_IN+1)-1:0]  out_pop,
  output logic                       out_toggle,
  output logic [CNT_W-1:0]           dissent_cnt,
  input  logic                       cnt_clr
);

  localparam int POP_W = pop_width(N_IN);
  localparam int CW    = $clog2(HOLD + 1);

  if (!params_legal(N_IN, THRESH, HOLD)) begin : g_bad_params
    $error("maj_vote_filter: illegal N_IN/THRESH/HOLD combination");
  end

  logic [POP_W-1:0] pop_c;
  logic             s1_valid;
  logic [POP_W-1:0] s1_pop;
  logic             s1_raw;
  logic             s1_unan;

  state_t           state, state_n;
  logic [CW-1:0]    run_cnt, cnt_n;
  logic             vote_n;
  logic             toggle_n;

  maj_vote_popcount #(.N_IN(N_IN), .POP_W(POP_W)) u_popcount (
    .vec (in_bits),
    .pop (pop_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pop   <= '0;
      s1_raw   <= 1'b0;
      s1_unan  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pop  <= pop_c;
        s1_raw  <= (int'(pop_c) >= THRESH);
        s1_unan <= (pop_c == '0) || (pop_c == POP_W'(N_IN));
      end
    end
  end

  // Filter only moves on processed samples, so gaps neither advance nor clear run_cnt.
  always_comb begin
    state_n  = state;
    cnt_n    = run_cnt;
    vote_n   = out_vote;
    toggle_n = 1'b0;
    if (s1_valid) begin
      if (s1_raw == out_vote) begin
        state_n = STABLE;
        cnt_n   = '0;
      end else if (state == STABLE && HOLD > 1) begin
        state_n = PEND;
        cnt_n   = CW'(1);
      end else if (state == STABLE || int'(run_cnt) + 1 >= HOLD) begin
        state_n  = STABLE;
        cnt_n    = '0;
        vote_n   = ~out_vote;
        toggle_n = 1'b1;
      end else begin
        cnt_n = run_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_toggle <= 1'b0;
      out_raw    <= 1'b0;
      out_pop    <= '0;
      out_vote   <= INIT_VAL;
      state      <= STABLE;
      run_cnt    <= '0;
    end else begin
      out_valid  <= s1_valid;
      out_toggle <= toggle_n;
      out_vote   <= vote_n;
      state      <= state_n;
      run_cnt    <= cnt_n;
      if (s1_valid) begin
        out_raw <= s1_raw;
        out_pop <= s1_pop;
      end
    end
  end

`ifdef MAJ_VOTE_DISSENT_EN
  // Clear takes priority over a coincident increment; count saturates.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      dissent_cnt <= '0;
    end else if (s1_valid && !s1_unan && dissent_cnt != '1) begin
      dissent_cnt <= dissent_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_dissent;
  assign unused_dissent = cnt_clr ^ s1_unan;
  assign dissent_cnt    = '0;
`endif

endmodule
